// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game datapath: FSM state encoding,
// screen and pipe geometry, and the bird scoring column. The pipe renderer
// and the collision logic import the same constants.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int NUM_PIPES    = 3;
  localparam int PIPE_WIDTH   = 104;
  localparam int PIPE_PITCH   = 256;
  localparam int PIPE_Y_START = 480;
  localparam int GAP_X_MIN    = 176;
  localparam int GAP_X_INIT   = GAP_X_MIN + 64;
  localparam int BIRD_Y_POS   = 120;
  localparam int SPEED_BASE   = 2;
  localparam int SCORE_MAX    = 999;

  // Score increment that sticks at the three-digit display limit.
  function automatic logic [9:0] score_inc(input logic [9:0] s);
    return (s >= 10'(SCORE_MAX)) ? s : s + 10'd1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise pipe gaps.
// Free-running: it shifts on every clock regardless of game state.
module lfsr16
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic        fb;

  // Next value: shift left, feed back the XOR of the tap bits.
  always_comb begin
    fb  = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];
    q_d = {q_q[14:0], fb};
  end

  // Register; a zero seed would lock the sequence, so it is replaced by 1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q <= (seed == 16'd0) ? 16'd1 : seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipe scroller / scorer for the flappy game. Three pipes scroll left by
// the current speed on each frame tick while running, wrap around with a
// fresh random gap, and a score pulse fires when a pipe's trailing edge
// crosses the bird column.
// Optional feature macro: PIPE_SPEEDUP_EN (speed grows with score, +1 per
// 8 points, capped at base+2). Default build uses a constant speed.
module pipe_ctrl
  import flappy_pkg::*;
#(
  parameter int          PIPE_W       = PIPE_WIDTH,
  parameter int          PIPE_SPACING = PIPE_PITCH,
  parameter int          Y_START      = PIPE_Y_START,
  parameter int          X_MIN        = GAP_X_MIN,
  parameter int          BIRD_Y       = BIRD_Y_POS,
  parameter int          SPEED0       = SPEED_BASE,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               hit,
  output logic signed [15:0] pos_x1,
  output logic signed [15:0] pos_x2,
  output logic signed [15:0] pos_x3,
  output logic signed [15:0] pos_y1,
  output logic signed [15:0] pos_y2,
  output logic signed [15:0] pos_y3,
  output logic               score_pulse,
  output logic [9:0]         score,
  output logic [1:0]         state
);

  localparam logic signed [15:0] PW_S   = 16'(PIPE_W);
  localparam logic signed [15:0] WRAP_S = 16'(3 * PIPE_SPACING);
  localparam logic signed [15:0] BY_S   = 16'(BIRD_Y);
  localparam logic signed [15:0] XI_S   = 16'(X_MIN + 64);
  localparam logic signed [15:0] SPD_S  = 16'(SPEED0);

  state_t             state_q, state_d;
  logic signed [15:0] pos_x_q [NUM_PIPES];
  logic signed [15:0] pos_x_d [NUM_PIPES];
  logic signed [15:0] pos_y_q [NUM_PIPES];
  logic signed [15:0] pos_y_d [NUM_PIPES];
  logic [9:0]         score_q, score_d;
  logic               score_pulse_q, score_pulse_d;

  logic [15:0]        lfsr_q;
  logic               unused_lfsr_bits;
  logic signed [15:0] gap_x;
  logic signed [15:0] speed;
  logic signed [15:0] y_step [NUM_PIPES];
  logic [NUM_PIPES-1:0] passed;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign unused_lfsr_bits = &{1'b0, lfsr_q[15:7]};
  assign gap_x = $signed(16'(X_MIN) + {9'd0, lfsr_q[6:0]});

`ifdef PIPE_SPEEDUP_EN
  // Speed level from the score before this update, capped at +2.
  always_comb begin
    speed = SPD_S + ((score_q[9:3] >= 7'd2) ? 16'sd2 : $signed({9'd0, score_q[9:3]}));
  end
`else
  // Constant scroll speed.
  always_comb begin
    speed = SPD_S;
  end
`endif

  // Candidate scrolled positions and the bird-column crossing test (pre-wrap).
  always_comb begin
    passed = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      y_step[i] = pos_y_q[i] - speed;
      passed[i] = (pos_y_q[i] + PW_S >= BY_S) && (y_step[i] + PW_S < BY_S);
    end
  end

  // Next-state and datapath update for the IDLE/RUN/STOP game FSM.
  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    score_d       = score_q;
    score_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (hit) begin
          state_d = ST_STOP;
        end else if (frame_tick) begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (y_step[i] <= -PW_S) begin
              pos_y_d[i] = y_step[i] + WRAP_S;
              pos_x_d[i] = gap_x;
            end else begin
              pos_y_d[i] = y_step[i];
            end
          end
          if (|passed) begin
            score_pulse_d = 1'b1;
            score_d       = score_inc(score_q);
          end
        end
      end
      ST_STOP: begin
        if (start) begin
          state_d = ST_RUN;
          score_d = '0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            pos_y_d[i] = 16'(Y_START + i * PIPE_SPACING);
            pos_x_d[i] = XI_S;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      score_q       <= '0;
      score_pulse_q <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pos_y_q[i] <= 16'(Y_START + i * PIPE_SPACING);
        pos_x_q[i] <= XI_S;
      end
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      score_pulse_q <= score_pulse_d;
      pos_y_q       <= pos_y_d;
      pos_x_q       <= pos_x_d;
    end
  end

  assign pos_x1      = pos_x_q[0];
  assign pos_x2      = pos_x_q[1];
  assign pos_x3      = pos_x_q[2];
  assign pos_y1      = pos_y_q[0];
  assign pos_y2      = pos_y_q[1];
  assign pos_y3      = pos_y_q[2];
  assign score       = score_q;
  assign score_pulse = score_pulse_q;
  assign state       = state_q;

endmodule
